// File: rtl/tabuleiro_vga.sv
// Tic-tac-toe board renderer for a 640x480@60 VGA output.
// Cell codes are snapshotted once per frame, and every output is registered one strobe behind the counters.
module tabuleiro_vga #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int BOARD_X0 = 170,
   parameter int BOARD_Y0 = 90,
   parameter int CELL     = 100,
   parameter int MARGIN   = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [17:0] cells,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        video_on,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int RAD     = CELL / 2 - MARGIN;

   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] HA       = 10'(H_ACTIVE);
   localparam logic [9:0] VA       = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] X0       = 10'(BOARD_X0);
   localparam logic [9:0] Y0       = 10'(BOARD_Y0);
   localparam logic [9:0] SIDE3    = 10'(3 * CELL);
   localparam logic [9:0] C1       = 10'(CELL);
   localparam logic [9:0] C2       = 10'(2 * CELL);
   localparam logic [9:0] G1L      = 10'(CELL - 2);
   localparam logic [9:0] G1H      = 10'(CELL + 1);
   localparam logic [9:0] G2L      = 10'(2 * CELL - 2);
   localparam logic [9:0] G2H      = 10'(2 * CELL + 1);
   localparam logic [9:0] MLO      = 10'(MARGIN);
   localparam logic [9:0] MHI      = 10'(CELL - 1 - MARGIN);
   localparam logic [9:0] ANTI     = 10'(CELL - 1);
   localparam logic [9:0] HALF     = 10'(CELL / 2);
   localparam logic [20:0] R_IN    = 21'((RAD - 4) * (RAD - 4));
   localparam logic [20:0] R_OUT   = 21'(RAD * RAD);

   logic [9:0]  hcnt, vcnt;
   logic [17:0] snap;

   logic [9:0]  bx, by, lx, ly;
   logic [9:0]  dxy, sxy, danti, adx, ady;
   logic [1:0]  col, row, code;
   logic [3:0]  idx;
   logic [20:0] dist2;
   logic        active, on_board, grid, in_mark, x_lit, o_lit, take_snap;
   logic [11:0] rgb;

   always_comb begin
      bx       = hcnt - X0;
      by       = vcnt - Y0;
      active   = (hcnt < HA) && (vcnt < VA);
      on_board = (hcnt >= X0) && (bx < SIDE3) && (vcnt >= Y0) && (by < SIDE3);

      // Cell index and cell-local offset by comparison against the cell boundaries
      if (bx < C1) begin
         col = 2'd0; lx = bx;
      end else if (bx < C2) begin
         col = 2'd1; lx = bx - C1;
      end else begin
         col = 2'd2; lx = bx - C2;
      end
      if (by < C1) begin
         row = 2'd0; ly = by;
      end else if (by < C2) begin
         row = 2'd1; ly = by - C1;
      end else begin
         row = 2'd2; ly = by - C2;
      end

      idx = {2'b00, row} * 4'd3 + {2'b00, col};
      case (idx)
         4'd0:    code = snap[1:0];
         4'd1:    code = snap[3:2];
         4'd2:    code = snap[5:4];
         4'd3:    code = snap[7:6];
         4'd4:    code = snap[9:8];
         4'd5:    code = snap[11:10];
         4'd6:    code = snap[13:12];
         4'd7:    code = snap[15:14];
         4'd8:    code = snap[17:16];
         default: code = 2'd0;
      endcase

      grid = (bx >= G1L && bx <= G1H) || (bx >= G2L && bx <= G2H) ||
             (by >= G1L && by <= G1H) || (by >= G2L && by <= G2H);

      in_mark = (lx >= MLO) && (lx <= MHI) && (ly >= MLO) && (ly <= MHI);
      dxy     = (lx >= ly) ? lx - ly : ly - lx;
      sxy     = lx + ly;
      danti   = (sxy >= ANTI) ? sxy - ANTI : ANTI - sxy;
      x_lit   = in_mark && ((dxy <= 10'd3) || (danti <= 10'd3));

      // Ring test on squared distance from the cell centre, using magnitudes only
      adx   = (lx >= HALF) ? lx - HALF : HALF - lx;
      ady   = (ly >= HALF) ? ly - HALF : HALF - ly;
      dist2 = 21'(adx) * 21'(adx) + 21'(ady) * 21'(ady);
      o_lit = (dist2 >= R_IN) && (dist2 <= R_OUT);

      rgb = 12'h000;
      if (active && on_board) begin
         if (grid)                      rgb = 12'hFFF;
         else if (code == 2'd1 && x_lit) rgb = 12'hF00;
         else if (code == 2'd2 && o_lit) rgb = 12'h00F;
      end

      take_snap = (hcnt == 10'd0) && (vcnt == VA);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hcnt        <= '0;
         vcnt        <= '0;
         snap        <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         hsync       <= !((hcnt >= HS_START) && (hcnt <= HS_END));
         vsync       <= !((vcnt >= VS_START) && (vcnt <= VS_END));
         video_on    <= active;
         red         <= rgb[11:8];
         green       <= rgb[7:4];
         blue        <= rgb[3:0];
         frame_start <= take_snap;
         if (take_snap) snap <= cells;
         if (hcnt == H_MAX) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_MAX) ? 10'd0 : vcnt + 10'd1;
         end else begin
            hcnt <= hcnt + 10'd1;
         end
      end
   end

endmodule

// File: tb/tb_tabuleiro_vga.sv
// Bench for tabuleiro_vga on a reduced raster so that whole frames fit in a short run.
// A behavioural model pushes the expected output word on each strobe; a consumer pops and compares after the edge.
module tb_tabuleiro_vga;
   localparam int HA = 80, HF = 4, HS = 8, HB = 8, HT = HA + HF + HS + HB;
   localparam int VA = 70, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
   localparam int X0 = 10, Y0 = 6, C = 20, M = 3;
   localparam int W = 36;
   localparam int LIMIT = 3 * HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en;
   logic        pix_gate = 1'b1;
   logic [17:0] cells = '0;
   logic        hsync, vsync, video_on, frame_start;
   logic [3:0]  red, green, blue;
   logic [15:0] dut_word;

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] sb_e;
   int m_h = 0, m_v = 0;
   logic [17:0] m_snap = '0;
   logic s_valid = 1'b0;
   int s_h = 0, s_v = 0;
   logic [17:0] p3;

   tabuleiro_vga #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .BOARD_X0(X0), .BOARD_Y0(Y0), .CELL(C), .MARGIN(M)
   ) dut (
      .clock(clk), .reset(reset), .pix_en(pix_en), .cells(cells),
      .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
      .video_on(video_on), .frame_start(frame_start)
   );

   assign dut_word = {frame_start, hsync, vsync, video_on, red, green, blue};

   always #5 clk = ~clk;

   initial begin
      pix_en = 1'b0;
      forever begin
         @(negedge clk);
         pix_en = pix_gate ? ~pix_en : 1'b0;
      end
   end

   function automatic logic [15:0] model_out(int h, int v, logic [17:0] sn);
      logic [11:0] rgb;
      logic hs_n, vs_n, von, fs;
      int bx, by, lx, ly, col, row, code, dx, dy, d, r;
      bit grid;
      rgb  = 12'h000;
      hs_n = !(h >= HA + HF && h < HA + HF + HS);
      vs_n = !(v >= VA + VF && v < VA + VF + VS);
      von  = (h < HA) && (v < VA);
      fs   = (h == 0) && (v == VA);
      bx = h - X0;
      by = v - Y0;
      if (von && bx >= 0 && by >= 0 && bx < 3 * C && by < 3 * C) begin
         col  = bx / C;
         row  = by / C;
         lx   = bx % C;
         ly   = by % C;
         code = int'((sn >> (2 * (3 * row + col))) & 18'd3);
         grid = ((bx + 2) % C < 4 && bx >= C - 2 && bx <= 2 * C + 1) ||
                ((by + 2) % C < 4 && by >= C - 2 && by <= 2 * C + 1);
         dx = lx - C / 2;
         dy = ly - C / 2;
         d  = dx * dx + dy * dy;
         r  = C / 2 - M;
         if (grid)
            rgb = 12'hFFF;
         else if (code == 1 && lx >= M && lx <= C - 1 - M && ly >= M && ly <= C - 1 - M &&
                  ((lx - ly <= 3 && ly - lx <= 3) ||
                   (lx + ly - (C - 1) <= 3 && (C - 1) - lx - ly <= 3)))
            rgb = 12'hF00;
         else if (code == 2 && d >= (r - 4) * (r - 4) && d <= r * r)
            rgb = 12'h00F;
      end
      return {fs, hs_n, vs_n, von, rgb};
   endfunction

   // Hand-derived pixels for the frame drawn with an empty snapshot: {video_on, rgb}
   function automatic int spot_empty(int h, int v);
      if (h == 30 && v == 11) return 'h1FFF;
      if (h == 14 && v == 10) return 'h1000;
      if (h == 5  && v == 20) return 'h1000;
      if (h == 85 && v == 20) return 'h0000;
      if (h == 54 && v == 50) return 'h1000;
      if (h == 43 && v == 36) return 'h1000;
      return -1;
   endfunction

   // Hand-derived pixels for cells = X at 0, O at 4, X at 8
   function automatic int spot_marks(int h, int v);
      if (h == 13 && v == 9)  return 'h1F00;
      if (h == 14 && v == 10) return 'h1F00;
      if (h == 14 && v == 14) return 'h1000;
      if (h == 12 && v == 8)  return 'h1000;
      if (h == 26 && v == 22) return 'h1F00;
      if (h == 27 && v == 23) return 'h1000;
      if (h == 14 && v == 21) return 'h1F00;
      if (h == 40 && v == 36) return 'h1000;
      if (h == 42 && v == 36) return 'h1000;
      if (h == 43 && v == 36) return 'h100F;
      if (h == 47 && v == 36) return 'h100F;
      if (h == 45 && v == 40) return 'h100F;
      if (h == 45 && v == 41) return 'h1000;
      if (h == 42 && v == 38) return 'h1000;
      if (h == 54 && v == 50) return 'h1F00;
      if (h == 30 && v == 36) return 'h1FFF;
      return -1;
   endfunction

   always @(posedge clk) begin
      s_valid <= 1'b0;
      if (reset) begin
         exp_q.push_back({10'd0, 10'd0, 16'h6000});
         m_h    <= 0;
         m_v    <= 0;
         m_snap <= '0;
      end else if (pix_en) begin
         exp_q.push_back({10'(m_h), 10'(m_v), model_out(m_h, m_v, m_snap)});
         s_valid <= 1'b1;
         s_h     <= m_h;
         s_v     <= m_v;
         if (m_h == 0 && m_v == VA) m_snap <= cells;
         if (m_h == HT - 1) begin
            m_h <= 0;
            m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h <= m_h + 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      while (exp_q.size() > 0) begin
         sb_e = exp_q.pop_front();
         total++;
         if (dut_word !== sb_e[15:0]) begin
            bad++;
            $display("FAIL scoreboard x=%0d y=%0d: got %h want %h", sb_e[35:26], sb_e[25:16],
                     dut_word, sb_e[15:0]);
         end
      end
   end

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (dut_word !== 16'h6000) begin
            bad++;
            $display("FAIL reset_state: got %h want 6000", dut_word);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_grid_frame();
      bit done = 0;
      int hs_low = 0;
      int e;
      for (int n = 0; n < LIMIT && !done; n++) begin
         @(posedge clk);
         #1;
         if (s_valid) begin
            if (s_h == 0 && s_v == 30) cells = 18'h10201;
            e = spot_empty(s_h, s_v);
            if (e >= 0) begin
               total++;
               if ({video_on, red, green, blue} !== 13'(e)) begin
                  bad++;
                  $display("FAIL grid_pixel (%0d,%0d): got %h want %h", s_h, s_v,
                           {video_on, red, green, blue}, 13'(e));
               end
            end
            if (!hsync) hs_low++;
            if (s_h == 0 && s_v == VA) begin
               done = 1;
               total++;
               if (frame_start !== 1'b1) begin
                  bad++;
                  $display("FAIL frame_start_pulse: got %b want 1", frame_start);
               end
            end
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL grid_frame_timeout: got no snapshot strobe want one");
      end
      total++;
      if (hs_low != VA * HS) begin
         bad++;
         $display("FAIL hsync_low_active_lines: got %0d want %0d", hs_low, VA * HS);
      end
   endtask

   task automatic test_marks_frame();
      bit done = 0;
      int strobes = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
      int e;
      for (int n = 0; n < LIMIT && !done; n++) begin
         @(posedge clk);
         #1;
         if (s_valid) begin
            strobes++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_start) fs_cnt++;
            if (s_h == 0 && s_v == 10) cells = 18'($urandom_range(0, 18'h3FFFF));
            if (s_h == HT - 1 && s_v == VA - 1) cells = p3;
            e = spot_marks(s_h, s_v);
            if (e >= 0) begin
               total++;
               if ({video_on, red, green, blue} !== 13'(e)) begin
                  bad++;
                  $display("FAIL mark_pixel (%0d,%0d): got %h want %h", s_h, s_v,
                           {video_on, red, green, blue}, 13'(e));
               end
            end
            if (s_h == 0 && s_v == VA) begin
               done = 1;
               cells = ~p3;
            end
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL marks_frame_timeout: got no snapshot strobe want one");
      end
      total++;
      if (strobes != HT * VT) begin
         bad++;
         $display("FAIL frame_length: got %0d want %0d", strobes, HT * VT);
      end
      total++;
      if (hs_low != VT * HS) begin
         bad++;
         $display("FAIL hsync_low_frame: got %0d want %0d", hs_low, VT * HS);
      end
      total++;
      if (vs_low != VS * HT) begin
         bad++;
         $display("FAIL vsync_low_frame: got %0d want %0d", vs_low, VS * HT);
      end
      total++;
      if (fs_cnt != 1) begin
         bad++;
         $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      bit done = 0;
      bit first = 0;
      for (int n = 0; n < LIMIT && !done; n++) begin
         @(posedge clk);
         #1;
         if (s_valid) begin
            if (s_h == 0 && s_v == 35) cells = 18'h00001;
            if (s_h == 20 && s_v == 40) done = 1;
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL reset_mid_timeout: got no line 40 want it");
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (dut_word !== 16'h6000) begin
         bad++;
         $display("FAIL reset_mid_outputs: got %h want 6000", dut_word);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      done = 0;
      for (int n = 0; n < LIMIT && !done; n++) begin
         @(posedge clk);
         #1;
         if (s_valid) begin
            if (!first) begin
               first = 1;
               total++;
               if ({video_on, hsync, vsync} !== 3'b111) begin
                  bad++;
                  $display("FAIL restart_pixel00: got %b want 111", {video_on, hsync, vsync});
               end
            end
            if (s_h == 14 && s_v == 10) begin
               done = 1;
               total++;
               if ({video_on, red, green, blue} !== 13'h1000) begin
                  bad++;
                  $display("FAIL snap_cleared: got %h want 1000", {video_on, red, green, blue});
               end
            end
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL restart_timeout: got no pixel (14,10) want it");
      end
   endtask

   task automatic test_pix_en_hold();
      logic [15:0] held;
      bit seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (s_valid) seen = 1;
      end
      pix_gate = 1'b0;
      held = dut_word;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (dut_word !== held) begin
            bad++;
            $display("FAIL pix_en_hold clock %0d: got %h want %h", i, dut_word, held);
         end
      end
      pix_gate = 1'b1;
      repeat (400) @(posedge clk);
      #2;
   endtask

   initial begin
      p3 = 18'($urandom);
      test_reset();
      test_grid_frame();
      test_marks_frame();
      test_reset_midframe();
      test_pix_en_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
